// File: rtl/lsq_fwd_pkg.sv
// Shared encodings, FSM state type and load-result extension for the LSQ.
package lsq_fwd_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Tag value meaning "no tag"; broadcasts and commits carrying it are ignored.
    localparam int ZERO_TAG = 0;

    // Width of the extension helper; callers cast to/from their XLEN.
    localparam int EXT_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD_WAIT  = 2'd1,
        ST_STORE_WAIT = 2'd2
    } lsq_state_e;

    // Byte: sign bit 7, half: sign bit 15, word: passed through unchanged.
    function automatic logic [EXT_W-1:0] extend_load(input logic [EXT_W-1:0] data,
                                                     input logic [1:0]       size,
                                                     input logic             sgn);
        logic [EXT_W-1:0] res;
        case (size)
            SZ_B:    res = {{(EXT_W-8){sgn & data[7]}}, data[7:0]};
            SZ_H:    res = {{(EXT_W-16){sgn & data[15]}}, data[15:0]};
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsq_fwd_overlap_check.sv
// Byte-range overlap and exact address/size match for one pair of accesses.
module lsq_overlap_check
    import lsq_fwd_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_addr,
    input  logic [1:0]      a_size,
    input  logic [XLEN-1:0] b_addr,
    input  logic [1:0]      b_size,
    output logic            overlap,
    output logic            exact
);

    // Access length in bytes; one extra bit keeps the end address from wrapping.
    function automatic logic [XLEN:0] span(input logic [1:0] size);
        logic [XLEN:0] len;
        case (size)
            SZ_B:    len = (XLEN+1)'(1);
            SZ_H:    len = (XLEN+1)'(2);
            SZ_W:    len = (XLEN+1)'(4);
            default: len = (XLEN+1)'(4);
        endcase
        return len;
    endfunction

    logic [XLEN:0] a_end;
    logic [XLEN:0] b_end;

    // Half-open ranges [addr, addr+len) intersect when each starts before the other ends.
    always_comb begin
        a_end   = {1'b0, a_addr} + span(a_size);
        b_end   = {1'b0, b_addr} + span(b_size);
        overlap = ({1'b0, a_addr} < b_end) && ({1'b0, b_addr} < a_end);
        exact   = (a_addr == b_addr) && (a_size == b_size);
    end

endmodule

// File: rtl/lsq_fwd.sv
// Load/store queue with out-of-order loads, exact-match store forwarding and
// in-order drain of committed stores through a single-ported memory.
module lsq_fwd
    import lsq_fwd_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TAG_W = 5,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [TAG_W-1:0] enq_tag,
    input  logic             enq_is_store,
    input  logic [1:0]       enq_size,
    input  logic             enq_signed,
    input  logic             iss_valid,
    input  logic [TAG_W-1:0] iss_tag,
    input  logic [XLEN-1:0]  iss_addr,
    input  logic [XLEN-1:0]  iss_data,
    input  logic             cmt_valid,
    input  logic [TAG_W-1:0] cmt_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic [XLEN-1:0]  out_data,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    output logic [1:0]       mem_size,
    input  logic             mem_ready,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] e_valid, e_store, e_sgn, e_aok, e_cmt, e_done;
    logic [1:0]       e_size [DEPTH];
    logic [TAG_W-1:0] e_tag  [DEPTH];
    logic [XLEN-1:0]  e_addr [DEPTH];
    logic [XLEN-1:0]  e_data [DEPTH];

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    lsq_state_e       state;

    logic [PTR_W-1:0] ld_idx;
    logic [TAG_W-1:0] ld_tag;
    logic [1:0]       ld_size;
    logic             ld_sgn;
    logic             ld_cancel;

    logic             cand_found;
    logic [PTR_W-1:0] cand_idx;
    logic [CNT_W-1:0] cand_k;
    logic             st_ok;
    logic             hit, hit_exact;
    logic [PTR_W-1:0] hit_idx;
    logic [CNT_W-1:0] keep;
    logic [DEPTH-1:0] keep_mask;
    logic [DEPTH-1:0] ov, ex;

    logic head_st_go, ld_retire, pop, enq_acc, ld_go, fwd_go;

    function automatic logic [PTR_W-1:0] slot(input logic [PTR_W-1:0] h, input int k);
        return h + PTR_W'(k);
    endfunction

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign enq_ready = !full;

    // Compare every entry against the selected load's byte range.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ov
        lsq_overlap_check #(.XLEN(XLEN)) u_ov (
            .a_addr  (e_addr[i]),
            .a_size  (e_size[i]),
            .b_addr  (e_addr[cand_idx]),
            .b_size  (e_size[cand_idx]),
            .overlap (ov[i]),
            .exact   (ex[i])
        );
    end

    // Oldest ready load whose older stores all know their address.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        cand_k     = '0;
        st_ok      = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < count && e_valid[slot(head, k)]) begin
                if (e_store[slot(head, k)]) begin
                    if (!e_aok[slot(head, k)]) st_ok = 1'b0;
                end else if (!cand_found && !e_done[slot(head, k)] &&
                             e_aok[slot(head, k)] && st_ok) begin
                    cand_found = 1'b1;
                    cand_idx   = slot(head, k);
                    cand_k     = CNT_W'(k);
                end
            end
        end
    end

    // Youngest older store overlapping the candidate decides forward/stall/read.
    always_comb begin
        hit       = 1'b0;
        hit_exact = 1'b0;
        hit_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < cand_k && e_store[slot(head, k)] && ov[slot(head, k)]) begin
                hit       = 1'b1;
                hit_exact = ex[slot(head, k)];
                hit_idx   = slot(head, k);
            end
        end
    end

    // Entries surviving a flush: head up to and including the youngest committed store.
    always_comb begin
        keep      = '0;
        keep_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < count && e_valid[slot(head, k)] &&
                e_store[slot(head, k)] && e_cmt[slot(head, k)])
                keep = CNT_W'(k + 1);
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < keep) keep_mask[slot(head, k)] = 1'b1;
        end
    end

    // Per-cycle decisions; flush blocks new enqueues and new load activity.
    always_comb begin
        head_st_go = (state == ST_IDLE) && !empty && e_store[head] &&
                     e_cmt[head] && e_aok[head];
        ld_retire  = !head_st_go && !flush && !empty && !e_store[head] && e_done[head];
        pop        = head_st_go || ld_retire;
        enq_acc    = enq_valid && !full && !flush;
        ld_go      = (state == ST_IDLE) && !head_st_go && !flush && cand_found && !hit;
        fwd_go     = (state == ST_IDLE) && !head_st_go && !flush && cand_found &&
                     hit && hit_exact;
    end

    // Queue state, entry updates and the memory/result FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            e_valid   <= '0;
            state     <= ST_IDLE;
            ld_cancel <= 1'b0;
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_data  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_size  <= '0;
        end else begin
            out_valid <= 1'b0;
            mem_req   <= 1'b0;

            head <= head + PTR_W'(pop);
            if (flush) begin
                tail  <= head + keep[PTR_W-1:0];
                count <= keep - CNT_W'(pop);
            end else begin
                tail  <= tail + PTR_W'(enq_acc);
                count <= count + CNT_W'(enq_acc) - CNT_W'(pop);
            end

            for (int i = 0; i < DEPTH; i++) begin
                if (flush) begin
                    if (!keep_mask[i]) e_valid[i] <= 1'b0;
                end else begin
                    if (e_valid[i] && iss_valid && iss_tag != TAG_W'(ZERO_TAG) &&
                        e_tag[i] == iss_tag) begin
                        e_aok[i]  <= 1'b1;
                        e_addr[i] <= iss_addr;
                        e_data[i] <= iss_data;
                    end
                    if (e_valid[i] && cmt_valid && cmt_tag != TAG_W'(ZERO_TAG) &&
                        e_tag[i] == cmt_tag)
                        e_cmt[i] <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (head_st_go) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= e_addr[head];
                        mem_wdata <= e_data[head];
                        mem_size  <= e_size[head];
                        state     <= ST_STORE_WAIT;
                    end else if (ld_go) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= e_addr[cand_idx];
                        mem_size  <= e_size[cand_idx];
                        ld_idx    <= cand_idx;
                        ld_tag    <= e_tag[cand_idx];
                        ld_size   <= e_size[cand_idx];
                        ld_sgn    <= e_sgn[cand_idx];
                        ld_cancel <= 1'b0;
                        state     <= ST_LOAD_WAIT;
                    end else if (fwd_go) begin
                        out_valid        <= 1'b1;
                        out_tag          <= e_tag[cand_idx];
                        out_data         <= XLEN'(extend_load(EXT_W'(e_data[hit_idx]),
                                                              e_size[cand_idx], e_sgn[cand_idx]));
                        e_done[cand_idx] <= 1'b1;
                    end
                end
                ST_LOAD_WAIT: begin
                    if (flush) ld_cancel <= 1'b1;
                    if (mem_ready) begin
                        state <= ST_IDLE;
                        if (!flush && !ld_cancel) begin
                            out_valid      <= 1'b1;
                            out_tag        <= ld_tag;
                            out_data       <= XLEN'(extend_load(EXT_W'(mem_rdata), ld_size, ld_sgn));
                            e_done[ld_idx] <= 1'b1;
                        end
                    end
                end
                ST_STORE_WAIT: begin
                    if (mem_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (enq_acc) begin
                e_valid[tail] <= 1'b1;
                e_store[tail] <= enq_is_store;
                e_size[tail]  <= enq_size;
                e_sgn[tail]   <= enq_signed;
                e_tag[tail]   <= enq_tag;
                e_aok[tail]   <= 1'b0;
                e_cmt[tail]   <= 1'b0;
                e_done[tail]  <= 1'b0;
            end
            if (pop) e_valid[head] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lsq_fwd.sv
// Directed bench for lsq_fwd: store drain, forwarding, partial-overlap stall,
// load bypass, full queue with flush, and flush of an outstanding load.
module tb_lsq_fwd;

    localparam int DEPTH = 16;
    localparam int TAG_W = 5;
    localparam int XLEN  = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             enq_valid = 1'b0;
    logic             enq_ready;
    logic [TAG_W-1:0] enq_tag = '0;
    logic             enq_is_store = 1'b0;
    logic [1:0]       enq_size = '0;
    logic             enq_signed = 1'b0;
    logic             iss_valid = 1'b0;
    logic [TAG_W-1:0] iss_tag = '0;
    logic [XLEN-1:0]  iss_addr = '0;
    logic [XLEN-1:0]  iss_data = '0;
    logic             cmt_valid = 1'b0;
    logic [TAG_W-1:0] cmt_tag = '0;
    logic             out_valid;
    logic [TAG_W-1:0] out_tag;
    logic [XLEN-1:0]  out_data;
    logic             mem_req;
    logic             mem_we;
    logic [XLEN-1:0]  mem_addr;
    logic [XLEN-1:0]  mem_wdata;
    logic [1:0]       mem_size;
    logic             mem_ready = 1'b0;
    logic [XLEN-1:0]  mem_rdata = '0;
    logic             full;
    logic             empty;

    int total = 0;
    int bad = 0;
    int mem_cnt = 0;
    int out_cnt = 0;

    lsq_fwd #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_tag(enq_tag),
        .enq_is_store(enq_is_store), .enq_size(enq_size), .enq_signed(enq_signed),
        .iss_valid(iss_valid), .iss_tag(iss_tag), .iss_addr(iss_addr), .iss_data(iss_data),
        .cmt_valid(cmt_valid), .cmt_tag(cmt_tag),
        .out_valid(out_valid), .out_tag(out_tag), .out_data(out_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Count request and result pulses between edges.
    always @(negedge clk) begin
        if (mem_req) mem_cnt++;
        if (out_valid) out_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input int tag, input bit st, input int sz, input bit sg);
        enq_valid    = 1'b1;
        enq_tag      = TAG_W'(tag);
        enq_is_store = st;
        enq_size     = 2'(sz);
        enq_signed   = sg;
        tick();
        enq_valid    = 1'b0;
    endtask

    task automatic iss(input int tag, input logic [31:0] addr, input logic [31:0] data);
        iss_valid = 1'b1;
        iss_tag   = TAG_W'(tag);
        iss_addr  = addr;
        iss_data  = data;
        tick();
        iss_valid = 1'b0;
    endtask

    task automatic cmt(input int tag);
        cmt_valid = 1'b1;
        cmt_tag   = TAG_W'(tag);
        tick();
        cmt_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rdata);
        mem_ready = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ready = 1'b0;
    endtask

    // Bounded wait for a memory request; checks its fields against the given ones.
    task automatic expect_mem(input string tag, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int sz);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (mem_req) seen = 1'b1;
            else tick();
        end
        chk({tag, "_req"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_we"}, 32'(mem_we), 32'(we));
            chk({tag, "_addr"}, mem_addr, addr);
            if (we) chk({tag, "_wdata"}, mem_wdata, wdata);
            chk({tag, "_size"}, 32'(mem_size), 32'(sz));
        end
    endtask

    // Bounded wait for a load result.
    task automatic expect_out(input string tag, input int otag, input logic [31:0] data);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else tick();
        end
        chk({tag, "_valid"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_tag"}, 32'(out_tag), 32'(otag));
            chk({tag, "_data"}, out_data, data);
        end
    endtask

    initial begin
        int m0, o0;

        repeat (3) tick();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_enq_ready", 32'(enq_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        tick();

        // Committed word store drains to memory.
        enq(3, 1'b1, 2, 1'b0);
        iss(3, 32'h100, 32'hDEADBEEF);
        chk("t1_not_empty", 32'(empty), 32'd0);
        cmt(3);
        expect_mem("t1_st", 1'b1, 32'h100, 32'hDEADBEEF, 2);
        respond(32'h0);
        chk("t1_empty", 32'(empty), 32'd1);

        // Exact match forwards without a memory access.
        m0 = mem_cnt;
        enq(1, 1'b1, 2, 1'b0);
        enq(2, 1'b0, 2, 1'b0);
        iss(1, 32'h40, 32'h12345678);
        iss(2, 32'h40, 32'h0);
        expect_out("t2_fwd", 2, 32'h12345678);
        tick();
        tick();
        chk("t2_no_mem", 32'(mem_cnt - m0), 32'd0);
        do_flush();
        chk("t2_flush_empty", 32'(empty), 32'd1);

        // Partial overlap stalls the load until the byte store drains.
        m0 = mem_cnt;
        o0 = out_cnt;
        enq(1, 1'b1, 0, 1'b0);
        enq(2, 1'b0, 1, 1'b1);
        iss(1, 32'h41, 32'h80);
        iss(2, 32'h40, 32'h0);
        repeat (5) tick();
        chk("t3_stall_mem", 32'(mem_cnt - m0), 32'd0);
        chk("t3_stall_out", 32'(out_cnt - o0), 32'd0);
        cmt(1);
        expect_mem("t3_st", 1'b1, 32'h41, 32'h80, 0);
        respond(32'h0);
        expect_mem("t3_ld", 1'b0, 32'h40, 32'h0, 1);
        respond(32'h00008000);
        expect_out("t3_out", 2, 32'hFFFF8000);
        tick();
        chk("t3_empty", 32'(empty), 32'd1);

        // Load bypasses an older uncommitted store to a different address.
        enq(5, 1'b1, 2, 1'b0);
        enq(4, 1'b0, 0, 1'b1);
        iss(5, 32'h300, 32'h11);
        iss(4, 32'h200, 32'h0);
        expect_mem("t4_ld", 1'b0, 32'h200, 32'h0, 0);
        respond(32'h000000F0);
        expect_out("t4_out", 4, 32'hFFFFFFF0);
        do_flush();
        chk("t4_flush_empty", 32'(empty), 32'd1);

        // Fill the queue behind a busy store, then flush keeping two committed stores.
        enq(6, 1'b1, 2, 1'b0);
        iss(6, 32'h500, 32'hA5);
        cmt(6);
        expect_mem("t5_st6", 1'b1, 32'h500, 32'hA5, 2);
        enq(7, 1'b1, 2, 1'b0);
        enq(8, 1'b1, 2, 1'b0);
        iss(7, 32'h504, 32'h5A);
        iss(8, 32'h508, 32'h3C);
        cmt(7);
        cmt(8);
        for (int i = 0; i < DEPTH - 2; i++) begin
            chk("t5_not_full", 32'(full), 32'd0);
            enq(10 + i, 1'b0, 2, 1'b0);
        end
        chk("t5_full", 32'(full), 32'd1);
        chk("t5_enq_ready", 32'(enq_ready), 32'd0);
        enq(24, 1'b1, 2, 1'b0);
        chk("t5_still_full", 32'(full), 32'd1);
        do_flush();
        chk("t5_flush_full", 32'(full), 32'd0);
        chk("t5_flush_not_empty", 32'(empty), 32'd0);
        respond(32'h0);
        expect_mem("t5_st7", 1'b1, 32'h504, 32'h5A, 2);
        respond(32'h0);
        expect_mem("t5_st8", 1'b1, 32'h508, 32'h3C, 2);
        respond(32'h0);
        chk("t5_drained", 32'(empty), 32'd1);

        // Flush during an outstanding load discards its result.
        enq(9, 1'b0, 2, 1'b0);
        iss(9, 32'h600, 32'h0);
        expect_mem("t6_ld", 1'b0, 32'h600, 32'h0, 2);
        o0 = out_cnt;
        do_flush();
        tick();
        respond(32'h55555555);
        repeat (3) tick();
        chk("t6_no_out", 32'(out_cnt - o0), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        enq(11, 1'b1, 2, 1'b0);
        iss(11, 32'h700, 32'h77);
        cmt(11);
        expect_mem("t6_next", 1'b1, 32'h700, 32'h77, 2);
        respond(32'h0);
        chk("t6_final_empty", 32'(empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsq_fwd.md
Name: lsq_fwd

Overview:
- Parametrised load/store queue, successor to the in-order LSQ.
- Sits between the dispatch stage, the CDB/address units, the ROB commit port and the single-ported memory controller.
- Loads may execute out of order past older stores whose addresses are known and do not overlap.
- Exact address/size matches with an older store are forwarded without a memory access.
- Committed stores drain in order from the head; rollback squashes every uncommitted entry.

Parameters:
- DEPTH, 16, queue entries (power of two, ≥2).
- TAG_W, 5, ROB tag width; tag 0 means "no tag".
- XLEN, 32, address and data width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  misprediction rollback.
- enq_valid  in  1  enqueue request.
- enq_ready  out  1  equals !full.
- enq_tag  in  TAG_W  ROB tag.
- enq_is_store  in  1  1 = store.
- enq_size  in  2  0 = byte, 1 = half, 2 = word.
- enq_signed  in  1  sign-extend load result.
- iss_valid  in  1  address/data broadcast.
- iss_tag  in  TAG_W  target tag.
- iss_addr  in  XLEN  effective address.
- iss_data  in  XLEN  store data.
- cmt_valid  in  1  ROB commit.
- cmt_tag  in  TAG_W  committed tag.
- out_valid  out  1  load result valid.
- out_tag  out  TAG_W  load tag.
- out_data  out  XLEN  extended load data.
- mem_req  out  1  one-cycle request pulse.
- mem_we  out  1  write request.
- mem_addr  out  XLEN  request address.
- mem_wdata  out  XLEN  write data.
- mem_size  out  2  request size.
- mem_ready  in  1  request complete.
- mem_rdata  in  XLEN  read data.
- full  out  1  all DEPTH entries occupied.
- empty  out  1  no entries.

Behaviour:
- Storage: circular buffer with head/tail pointers of log2(DEPTH) bits plus a count; wrap at DEPTH-1→0. full = (count==DEPTH); empty = (count==0).
- Per-entry state: valid, is_store, size, signed, tag, addr_ok, addr, data, committed, done.
- Reset: pointers/count 0, all entry valid bits 0, FSM IDLE. Outputs out_valid, mem_req, mem_we, out_tag, out_data, mem_addr, mem_wdata, mem_size all 0.
- Enqueue: accepted when enq_valid && !full. Enqueue while full is ignored.
- Broadcast: iss_valid with nonzero tag matching a valid entry sets addr_ok, addr and data the same cycle. cmt_valid with a match sets committed. A single entry may be enqueued, broadcast and committed in distinct cycles; same-cycle enqueue plus broadcast to the new tag is not required.
- FSM states: IDLE, LOAD_WAIT, STORE_WAIT.
- IDLE priority 1: if head is a committed store with addr_ok, issue the write: mem_req=1, mem_we=1, size/addr/data from the entry. Pop head; go to STORE_WAIT.
- IDLE priority 2: otherwise pick the oldest valid, !done load with addr_ok whose older stores all have addr_ok.
  - Scan older stores youngest-first; the first byte-overlapping store decides.
  - Exact match (same addr, same size): forward. Emit out_valid next cycle with store data extended per load size/sign; mark done. No memory access.
  - Partial overlap: the load stalls until that store drains.
  - No overlap: issue the read (mem_req=1, mem_we=0); record tag and entry index; go to LOAD_WAIT.
- LOAD_WAIT/STORE_WAIT:
  - mem_req is low.
  - On mem_ready, return to IDLE.
  - For a load: out_valid=1 with out_tag and sign/zero extension (byte: bit 7, half: bit 15, word: unchanged); mark the entry done.
  - One outstanding memory op at a time.
- Retire: each cycle a done load at head is popped. At most one pop per cycle; a store pop has priority.
- Output timing: out_valid is a one-cycle pulse; at most one result per cycle. A memory response beats a forward; the forward retries next cycle.
- Flush:
  - All uncommitted entries are invalidated.
  - tail is set to one past the youngest committed store; count is recomputed; empty if none remain.
  - A pending load in LOAD_WAIT is cancelled: the FSM waits for mem_ready, discards the data, asserts no out_valid, then goes to IDLE.
  - STORE_WAIT completes normally.
  - Flush has priority over same-cycle enqueue and broadcast.
  - Committed stores are always contiguous from head.
- Reset mid-operation aborts everything. The memory controller is reset by the same rst.

Decomposition:
- Shared package:
  - size encodings SZ_B/SZ_H/SZ_W.
  - ZERO_TAG.
  - FSM state enum.
  - the extend_load function (data, size, signed → XLEN).
- Sub-module lsq_overlap_check: combinational byte-range overlap and exact-match comparator for one address/size pair, instantiated per entry.

Test Plan:
- Reset, then enqueue store SW(tag 3), issue addr 0x100 data 0xDEADBEEF, commit 3 → mem_req with we=1, addr 0x100, wdata 0xDEADBEEF, size 2; queue empty after mem_ready.
- Enqueue SW tag 1 @0x40 data 0x12345678, then LW tag 2 @0x40, no commit → out_valid tag 2 data 0x12345678, no mem_req.
- SB tag 1 @0x41 data 0x80, then LH signed tag 2 @0x40 → partial overlap stalls the load. Commit 1, store drains, load reads memory (mem_rdata 0x00008000) → out_data 0xFFFF8000.
- LB signed tag 4 @0x200 with older store @0x300 not committed → load bypasses; mem_rdata 0x000000F0 → out_data 0xFFFFFFF0.
- Fill DEPTH entries → full=1, enq_ready=0, extra enqueue dropped. flush with two committed stores at head → count 2, both still drain.
- LW in LOAD_WAIT, flush asserted, mem_ready two cycles later → no out_valid; FSM back to IDLE; next request accepted.
